nibble_serial_adder: RTL and testbench

- Sequential wrapper that adds two wide operands four bits per clock by driving the team's existing 4-bit `adder` (ports a, b, cin, sum, cout).
- It sits directly around that adder. It feeds it one operand nibble pair plus a registered carry each cycle, and consumes its sum/cout into a result register.
- Upstream and downstream connect through valid/ready handshakes.

---
 rtl/nibble_serial_adder.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: walks two W-bit operands through a 4-bit adder one nibble
// per clock, with valid/ready handshakes on both sides.

module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SW = IW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           in_ready_d, out_valid_d, busy_d, cout_d;

  logic [SW-1:0]  shamt;
  logic [3:0]     nib_a, nib_b, nib_s;
  logic           nib_c;

  // Current nibble selected by shifting the latched operands down by 4*idx.
  assign shamt = {idx_q, 2'b00};
  assign nib_a = 4'(a_q >> shamt);
  assign nib_b = 4'(b_q >> shamt);

  adder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum;
    cout_d      = cout;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          a_d        = op_a;
          b_d        = op_b;
          carry_d    = cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum & ~(W'(4'hF) << shamt)) | (W'(nib_s) << shamt);
        carry_d = nib_c;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NIBBLES - 1)) begin
          cout_d      = nib_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      sum       <= sum_d;
      cout      <= cout_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: 4-nibble instance with directed and
// random traffic, plus a 1-nibble instance.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] op_a, op_b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [3:0]  op_a1, op_b1, sum1;

  int          checks = 0;
  int          errors = 0;
  bit          rand_rdy = 1'b0;
  bit          rdy_force = 1'b1;

  logic [16:0] exp_q[$];
  logic [4:0]  exp1_q[$];
  logic [16:0] mon_e;
  logic [4:0]  mon1_e;

  nibble_serial_adder #(.NIBBLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .op_a      (op_a1),
    .op_b      (op_b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready changes just after the rising edge so the monitors see it settled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitors: a result is consumed on the edge following a negedge with valid&&ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result4", 32'({cout, sum}), 32'(mon_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        chk("spurious_out_valid1", 32'(out_valid1), 32'd0);
      end else begin
        mon1_e = exp1_q.pop_front();
        chk("result1", 32'({cout1, sum1}), 32'(mon1_e));
      end
    end
  end

  // Present an operation; returns on the negedge after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [16:0] e);
    int n;
    n = 0;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [4:0] e);
    int n;
    n = 0;
    @(negedge clk);
    op_a1 = a; op_b1 = b; cin1 = c; in_valid1 = 1'b1;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready1) begin
      chk("send1_timeout", 32'(in_ready1), 32'd1);
      in_valid1 = 1'b0;
      return;
    end
    exp1_q.push_back(e);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("lat1_e0", 32'(out_valid1), 32'd0);
    @(negedge clk);
    chk("lat1_e1", 32'(out_valid1), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", 32'(exp_q.size()), 32'd0);
    chk("drain1", 32'(exp1_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] s_hold;
    logic        c_hold;
    logic [15:0] ra, rb;
    logic        rc;
    logic [3:0]  ra1, rb1;
    logic        rc1;
    int          n;

    rst_n = 1'b0;
    in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    in_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum_cout", 32'({cout, sum}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Basic op with exact latency.
    send(16'h1234, 16'h4321, 1'b1, 17'h0_5556);
    chk("lat_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_k%0d", k), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
    end

    // Carry ripple through all nibbles.
    send(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    drain(100);

    // Backpressure with a held in_valid carrying new operands.
    rdy_force = 1'b0;
    @(posedge clk); #2;
    send(16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    s_hold = sum;
    c_hold = cout;
    op_a = 16'hA5A5; op_b = 16'h5A5A; cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_sum_stable", 32'(sum), 32'(s_hold));
      chk("bp_cout_stable", 32'(cout), 32'(c_hold));
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_high", 32'(out_valid), 32'd1);
    end
    rdy_force = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_idle", 32'(busy), 32'd0);
    exp_q.push_back(17'h1_0000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_held_accepted", 32'(busy), 32'd1);
    drain(100);

    // Operand changes after accept must not affect the result.
    send(16'h2468, 16'h1357, 1'b0, 17'h0_37BF);
    op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
    @(negedge clk);
    op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
    drain(100);

    // Reset during RUN discards the operation.
    send(16'hABCD, 16'h1111, 1'b1, 17'h0_BCDF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum_cout", 32'({cout, sum}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000);
    drain(100);

    // Random back-to-back traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
    end
    drain(200);
    rand_rdy = 1'b0;
    rdy_force = 1'b1;

    // Single-nibble instance.
    send1(4'hF, 4'h1, 1'b0, 5'h10);
    send1(4'h7, 4'h8, 1'b1, 5'h10);
    send1(4'h3, 4'h4, 1'b0, 5'h07);
    send1(4'hF, 4'hF, 1'b1, 5'h1F);
    for (int i = 0; i < 10; i++) begin
      ra1 = 4'($urandom);
      rb1 = 4'($urandom);
      rc1 = 1'($urandom);
      send1(ra1, rb1, rc1, 5'(ra1) + 5'(rb1) + 5'(rc1));
    end
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
